// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 keyboard encoder slice: prefix byte
//   values, the list of controller bytes that never become key events,
//   the ps2_key event layout and the frame receiver state encoding.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;  // extended-key prefix
    localparam logic [7:0] PS2_BRK    = 8'hF0;  // break (release) prefix
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;  // Pause prefix, followed by junk bytes

    // Keyboard housekeeping bytes: never key codes
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_OVR0   = 8'h00;
    localparam logic [7:0] PS2_OVR1   = 8'hFF;

    // ps2_key[10:0] as seen by core tops
    typedef struct packed {
        logic       tgl;
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } ps2_key_t;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_DATA,
        FR_PARITY,
        FR_STOP
    } frame_state_t;

    function automatic logic is_dropped(input logic [7:0] b);
        return b inside {PS2_BAT_OK, PS2_ACK, PS2_ECHO, PS2_RESEND, PS2_OVR0, PS2_OVR1};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
//   Receives device-to-host PS/2 frames: synchronises and de-glitches the raw
//   clock/data lines, samples data on each filtered clock falling edge and
//   checks start, odd parity and stop bits. A stalled frame is abandoned after
//   TIMEOUT_CYC cycles without a clock edge.
// Ports
//   clk_sys, reset_n      : system clock, async active-low reset
//   ps2_clk_in/ps2_dat_in : raw PS/2 lines (async, idle high)
//   rx_byte               : last received byte, valid while byte_vld
//   byte_vld              : one-cycle pulse for a good frame
//   frame_err             : one-cycle pulse for start/parity/stop/timeout error
//   timeout               : one-cycle pulse for the timeout case only
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 96000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frame_err,
    output logic       timeout
);

    localparam int unsigned FW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    // index 0 = clock line, 1 = data line
    logic [1:0]    r_s1, r_s2, r_filt;
    logic [FW-1:0] r_fcnt [2];
    logic          r_clk_fd;

    frame_state_t  r_state, w_state_nxt;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_tocnt;
    logic          r_byte_vld, r_frame_err, r_timeout;

    logic w_fall, w_dat, w_byte_ok, w_err, w_tmo;

    // Synchroniser plus stability filter: a line is accepted only after the
    // synchronised value has differed from the filtered value for FILTER_LEN
    // consecutive cycles.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_s1     <= '1;
            r_s2     <= '1;
            r_filt   <= '1;
            r_clk_fd <= 1'b1;
            for (int unsigned i = 0; i < 2; i++) r_fcnt[i] <= '0;
        end else begin
            r_s1     <= {ps2_dat_in, ps2_clk_in};
            r_s2     <= r_s1;
            r_clk_fd <= r_filt[0];
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_s2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    r_filt[i] <= r_s2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + FW'(1);
                end
            end
        end
    end

    assign w_fall = r_clk_fd & ~r_filt[0];
    assign w_dat  = r_filt[1];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= FR_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Timeout can only fire in a cycle without an edge, so it never collides
    // with a completed byte.
    always_comb begin
        w_state_nxt = r_state;
        w_byte_ok   = 1'b0;
        w_err       = 1'b0;
        w_tmo       = (r_state != FR_IDLE) && !w_fall && (r_tocnt == TW'(TIMEOUT_CYC - 1));
        if (w_tmo) begin
            w_state_nxt = FR_IDLE;
        end else if (w_fall) begin
            case (r_state)
                FR_IDLE: begin
                    if (!w_dat) w_state_nxt = FR_DATA;
                    else        w_err       = 1'b1;
                end
                FR_DATA: begin
                    if (r_bitcnt == 3'd7) w_state_nxt = FR_PARITY;
                end
                FR_PARITY: w_state_nxt = FR_STOP;
                FR_STOP: begin
                    w_state_nxt = FR_IDLE;
                    if (w_dat && (^{r_shift, r_par})) w_byte_ok = 1'b1;
                    else                              w_err     = 1'b1;
                end
                default: w_state_nxt = FR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_tocnt     <= '0;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_byte_vld  <= w_byte_ok;
            r_frame_err <= w_err | w_tmo;
            r_timeout   <= w_tmo;

            if (w_fall || r_state == FR_IDLE) r_tocnt <= '0;
            else                              r_tocnt <= r_tocnt + TW'(1);

            if (w_fall && !w_tmo) begin
                case (r_state)
                    FR_IDLE:   r_bitcnt <= '0;
                    FR_DATA: begin
                        r_shift  <= {w_dat, r_shift[7:1]};  // LSB arrives first
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    FR_PARITY: r_par <= w_dat;
                    default:   ;
                endcase
            end
        end
    end

    assign rx_byte   = r_shift;
    assign byte_vld  = r_byte_vld;
    assign frame_err = r_frame_err;
    assign timeout   = r_timeout;

endmodule

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder
//   Turns raw PS/2 keyboard traffic into ps2_key[10:0] events. E0 and F0
//   prefixes are folded into the following byte, E1 (Pause) swallows the
//   next E1_SKIP bytes, housekeeping bytes are discarded.
// Ports
//   clk_sys, reset_n      : system clock, async active-low reset
//   ps2_clk_in/ps2_dat_in : raw PS/2 lines
//   ps2_key               : [10] toggle, [9] pressed, [8] extended, [7:0] code
//   key_stb               : one-cycle pulse when ps2_key changes
//   frame_err             : one-cycle pulse on a bad or stalled frame
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 96000,
    parameter int unsigned E1_SKIP     = 7
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic [10:0] ps2_key,
    output logic        key_stb,
    output logic        frame_err
);

    localparam int unsigned SKW = (E1_SKIP < 2) ? 1 : $clog2(E1_SKIP + 1);

    logic [1:0]     r_rst_sync;
    logic           w_rst_n;
    logic [7:0]     w_byte;
    logic           w_byte_vld, w_timeout;

    ps2_key_t       r_key;
    logic           r_stb, r_ext, r_brk;
    logic [SKW-1:0] r_skip;

    // Reset asserts immediately, releases on a clock edge
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= '0;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_sys    (clk_sys),
        .reset_n    (w_rst_n),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .rx_byte    (w_byte),
        .byte_vld   (w_byte_vld),
        .frame_err  (frame_err),
        .timeout    (w_timeout)
    );

    // Prefixes only set flags, so E0 F0 xx and F0 E0 xx end up identical
    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_key  <= '0;
            r_stb  <= 1'b0;
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= '0;
        end else begin
            r_stb <= 1'b0;
            if (w_timeout) begin
                r_ext  <= 1'b0;
                r_brk  <= 1'b0;
                r_skip <= '0;
            end else if (w_byte_vld) begin
                if (r_skip != '0) begin
                    r_skip <= r_skip - SKW'(1);
                end else if (w_byte == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else if (w_byte == PS2_PAUSE) begin
                    r_skip <= SKW'(E1_SKIP);
                end else if (is_dropped(w_byte)) begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end else begin
                    r_key <= '{tgl: ~r_key.tgl, pressed: ~r_brk, ext: r_ext, code: w_byte};
                    r_stb <= 1'b1;
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end

    assign ps2_key = r_key;
    assign key_stb = r_stb;

endmodule

// File: tb/tb_ps2_key_encoder.sv
module tb_ps2_key_encoder;

    localparam int unsigned FLEN = 8;
    localparam int unsigned TMO  = 400;
    localparam int unsigned E1S  = 7;
    localparam int          HALF = 50;   // PS/2 half period in clk_sys cycles

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_dat_in = 1'b1;
    logic [10:0] ps2_key;
    logic        key_stb;
    logic        frame_err;

    int checks = 0;
    int failures = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int s0, e0;

    always #10 clk_sys = ~clk_sys;

    ps2_key_encoder #(
        .FILTER_LEN  (FLEN),
        .TIMEOUT_CYC (TMO),
        .E1_SKIP     (E1S)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_key    (ps2_key),
        .key_stb    (key_stb),
        .frame_err  (frame_err)
    );

    always @(negedge clk_sys) begin
        if (key_stb === 1'b1)   stb_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat_in = b;
        wait_cyc(HALF / 2);
        ps2_clk_in = 1'b0;
        wait_cyc(HALF);
        ps2_clk_in = 1'b1;
        wait_cyc(HALF / 2);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_dat_in = 1'b1;
        wait_cyc(20);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        wait_cyc(10);
        check("rst_key", 32'(ps2_key), 32'h000);
        check("rst_stb", 32'(key_stb), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        wait_cyc(30);

        // A make
        s0 = stb_cnt; e0 = err_cnt;
        send_byte(8'h1C, 1'b0);
        check("t1_key", 32'(ps2_key), 32'h61C);
        check("t1_stb", 32'(stb_cnt - s0), 32'd1);
        check("t1_err", 32'(err_cnt - e0), 32'd0);

        // A break
        s0 = stb_cnt;
        send_byte(8'hF0, 1'b0);
        check("t2_f0_key", 32'(ps2_key), 32'h61C);
        send_byte(8'h1C, 1'b0);
        check("t2_key", 32'(ps2_key), 32'h01C);
        check("t2_stb", 32'(stb_cnt - s0), 32'd1);

        // extended up make / break
        s0 = stb_cnt;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("t3_make", 32'(ps2_key), 32'h775);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("t3_break", 32'(ps2_key), 32'h175);
        check("t3_stb", 32'(stb_cnt - s0), 32'd2);

        // bad parity, then good frame
        s0 = stb_cnt; e0 = err_cnt;
        send_byte(8'h14, 1'b1);
        check("t4_err", 32'(err_cnt - e0), 32'd1);
        check("t4_key_kept", 32'(ps2_key), 32'h175);
        check("t4_no_stb", 32'(stb_cnt - s0), 32'd0);
        send_byte(8'h14, 1'b0);
        check("t4_key", 32'(ps2_key), 32'h614);

        // E0, then stalled frame: timeout drops the partial byte and E0
        send_byte(8'hE0, 1'b0);
        s0 = stb_cnt; e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_dat_in = 1'b1;
        wait_cyc(1000);
        check("t5_tmo_err", 32'(err_cnt - e0), 32'd1);
        check("t5_tmo_stb", 32'(stb_cnt - s0), 32'd0);
        send_byte(8'h29, 1'b0);
        check("t5_key", 32'(ps2_key), 32'h229);
        check("t5_err_once", 32'(err_cnt - e0), 32'd1);

        // short clock glitches are filtered, a long one is a real edge
        e0 = err_cnt;
        for (int w = 5; w <= 7; w += 2) begin
            ps2_clk_in = 1'b0;
            wait_cyc(w);
            ps2_clk_in = 1'b1;
            wait_cyc(40);
        end
        check("glitch_rejected", 32'(err_cnt - e0), 32'd0);
        ps2_clk_in = 1'b0;
        wait_cyc(12);
        ps2_clk_in = 1'b1;
        wait_cyc(40);
        check("glitch_long_edge", 32'(err_cnt - e0), 32'd1);

        // Pause prefix swallows 7 bytes; ACK is dropped and clears E0
        s0 = stb_cnt;
        send_byte(8'hE1, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'hE1, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h77, 1'b0);
        check("e1_no_stb", 32'(stb_cnt - s0), 32'd0);
        check("e1_key_kept", 32'(ps2_key), 32'h229);
        send_byte(8'h1C, 1'b0);
        check("e1_after", 32'(ps2_key), 32'h61C);
        send_byte(8'hF0, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("f0e0_key", 32'(ps2_key), 32'h175);
        s0 = stb_cnt;
        send_byte(8'hE0, 1'b0);
        send_byte(8'hFA, 1'b0);
        check("ack_no_stb", 32'(stb_cnt - s0), 32'd0);
        send_byte(8'h1C, 1'b0);
        check("ack_clears_ext", 32'(ps2_key), 32'h61C);

        // reset in the middle of E0 75
        send_byte(8'hE0, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset_n = 1'b0;
        wait_cyc(5);
        check("t6_rst_key", 32'(ps2_key), 32'h000);
        ps2_dat_in = 1'b1;
        ps2_clk_in = 1'b1;
        wait_cyc(5);
        reset_n = 1'b1;
        wait_cyc(30);
        s0 = stb_cnt; e0 = err_cnt;
        send_byte(8'h75, 1'b0);
        check("t6_key", 32'(ps2_key), 32'h675);
        check("t6_stb", 32'(stb_cnt - s0), 32'd1);
        check("t6_err", 32'(err_cnt - e0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
